// File: rtl/uart_boot_pkg.sv
// Shared types and defaults for the UART boot loader.
package uart_boot_pkg;

    // Loader states: collecting bytes, writing a word, load finished.
    typedef enum logic [1:0] {
        RECV  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } boot_state_e;

    // Receiver states for one 8N1 frame.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam logic [31:0] END_WORD_DEFAULT = 32'h0000_0FFF;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchronizer, start-bit glitch rejection,
// LSB-first data sampling and stop-bit framing check.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | counting to mid start bit; high there means glitch
// RX_DATA  | sampling 8 data bits, one per bit period
// RX_STOP  | sampling stop bit; high -> byte valid, low -> frame error
module uart_rx_byte
    import uart_boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sync1_q, sync2_q, prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Frame sequencing; the bit timer is a down-counter sampled at zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (sync2_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d   = RX_DATA;
                        cnt_d     = BIT_LOAD;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d   = {sync2_q, shift_q[7:1]};
                    cnt_d     = BIT_LOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    state_d = RX_IDLE;
                    if (sync2_q) valid_d = 1'b1;
                    else         ferr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Synchronizer, edge-detect history and receiver registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= rx_i;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_valid_o     = valid_q;
    assign rx_byte_o      = shift_q;
    assign rx_frame_err_o = ferr_q;

endmodule

// File: rtl/uart_boot_ctrl.sv
// Boot loader: assembles UART bytes into little-endian words, writes them
// to instruction memory over req/gnt and releases the core on END_WORD.
//
// state | meaning
// RECV  | collecting bytes 0..3 of the next word
// WRITE | request held until mem_gnt_i; new bytes go to the holding register
// DONE  | load finished, core released, UART ignored until reset
module uart_boot_ctrl
    import uart_boot_pkg::*;
#(
    parameter int                CLKS_PER_BIT = 10417,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int                MAX_WORDS    = 4096,
    parameter logic [31:0]       END_WORD     = END_WORD_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              uart_rx_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    output logic              core_rst_no,
    output logic              boot_done_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic [15:0]       word_cnt_o
);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_frame_err;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .rx_i           (uart_rx_i),
        .rx_valid_o     (rx_valid),
        .rx_byte_o      (rx_byte),
        .rx_frame_err_o (rx_frame_err)
    );

    boot_state_e       state_q, state_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic              done_q, done_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    logic              byte_vld;
    logic [7:0]        byte_in;
    logic [31:0]       word_full;

    // Loader next-state: byte assembly, write handshake, sticky flags.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        byte_idx_d  = byte_idx_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        req_d       = req_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        word_cnt_d  = word_cnt_q;
        overrun_d   = overrun_q;
        done_d      = (state_q == DONE);
        frame_err_d = frame_err_q | (rx_frame_err & (state_q != DONE));
        byte_vld    = 1'b0;
        byte_in     = rx_byte;
        word_full   = word_q;
        case (state_q)
            RECV: begin
                // A held byte is always older than one arriving now.
                if (hold_vld_q) begin
                    byte_vld   = 1'b1;
                    byte_in    = hold_q;
                    hold_vld_d = rx_valid;
                    if (rx_valid) hold_d = rx_byte;
                end else if (rx_valid) begin
                    byte_vld = 1'b1;
                end
                if (byte_vld) begin
                    word_full[{byte_idx_q, 3'b000} +: 8] = byte_in;
                    word_d     = word_full;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        if (word_full == END_WORD) begin
                            state_d = DONE;
                        end else begin
                            state_d = WRITE;
                            req_d   = 1'b1;
                            wdata_d = word_full;
                            addr_d  = BASE_ADDR + ADDR_W'({word_cnt_q, 2'b00});
                        end
                    end
                end
            end
            WRITE: begin
                if (rx_valid) begin
                    if (hold_vld_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        hold_vld_d = 1'b1;
                        hold_d     = rx_byte;
                    end
                end
                if (mem_gnt_i) begin
                    req_d      = 1'b0;
                    word_cnt_d = word_cnt_q + 16'd1;
                    state_d    = (word_cnt_q + 16'd1 == 16'(MAX_WORDS)) ? DONE : RECV;
                end
            end
            default: ;
        endcase
    end

    // Loader registers; every output comes straight from a flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RECV;
            word_q      <= 32'h0;
            byte_idx_q  <= 2'd0;
            hold_q      <= 8'h00;
            hold_vld_q  <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= BASE_ADDR;
            wdata_q     <= 32'h0;
            word_cnt_q  <= 16'd0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            byte_idx_q  <= byte_idx_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            word_cnt_q  <= word_cnt_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = req_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign core_rst_no = done_q;
    assign boot_done_o = done_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign word_cnt_o  = word_cnt_q;

endmodule
